// File: rtl/vga_if.sv
// vga_if: pixel-tick/restart controls and raster timing outputs of the VGA timing generator.
interface vga_if #(
    parameter int CNT_W = 11
);
    logic             en;
    logic             frame_restart;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             de;
    logic             new_line;
    logic             new_frame;

    modport master (
        input  en, frame_restart,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, de, new_line, new_frame
    );

    modport slave (
        output en, frame_restart,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, de, new_line, new_frame
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with pixel enable, sync polarity and frame restart.
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 1024,
    parameter int   H_FP      = 24,
    parameter int   H_SYNC    = 136,
    parameter int   H_BP      = 160,
    parameter int   V_ACTIVE  = 768,
    parameter int   V_FP      = 3,
    parameter int   V_SYNC    = 6,
    parameter int   V_BP      = 29,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CNT_W     = 11
) (
    input  logic  clk,
    input  logic  rst_n,
    vga_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    if ((2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_width_check
        $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end

    logic             pending;
    logic             restart;
    logic [CNT_W-1:0] nh;
    logic [CNT_W-1:0] nv;

    // Next raster position; a restart (live or pending) overrides the natural advance.
    always_comb begin
        restart = bus.frame_restart | pending;
        nh = (restart || bus.hcount == H_MAX) ? '0 : bus.hcount + 1'b1;
        nv = restart ? '0 : (bus.hcount != H_MAX) ? bus.vcount : (bus.vcount == V_MAX) ? '0 : bus.vcount + 1'b1;
    end

    // Register position and all flags together from the next position so nothing skews.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= 1'b0;
            bus.hcount    <= H_MAX;
            bus.vcount    <= V_MAX;
            bus.hblnk     <= 1'b1;
            bus.vblnk     <= 1'b1;
            bus.de        <= 1'b0;
            bus.hsync     <= ~HSYNC_POL;
            bus.vsync     <= ~VSYNC_POL;
            bus.new_line  <= 1'b0;
            bus.new_frame <= 1'b0;
        end else begin
            pending       <= ~bus.en & restart;
            bus.new_line  <= bus.en & (nh == '0);
            bus.new_frame <= bus.en & (nh == '0) & (nv == '0);
            if (bus.en) begin
                bus.hcount <= nh;
                bus.vcount <= nv;
                bus.hblnk  <= nh >= H_VIS;
                bus.vblnk  <= nv >= V_VIS;
                bus.de     <= (nh < H_VIS) && (nv < V_VIS);
                bus.hsync  <= (nh >= HS_BEG && nh <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
                bus.vsync  <= (nv >= VS_BEG && nv <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: raster-index model plus directed checks for small, inverted-polarity and XGA modes.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic fr = 1'b0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_if #(.CNT_W(4))  ia ();
    vga_if #(.CNT_W(4))  ib ();
    vga_if #(.CNT_W(11)) ic ();
    assign ia.en = en;
    assign ib.en = en;
    assign ic.en = en;
    assign ia.frame_restart = fr;
    assign ib.frame_restart = fr;
    assign ic.frame_restart = fr;

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    vga_timing_gen dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    // Mode tables: index 0 = small test mode, 1 = XGA default.
    int ha[2]  = '{8, 1024};
    int hfp[2] = '{2, 24};
    int hsy[2] = '{2, 136};
    int hbp[2] = '{2, 160};
    int va[2]  = '{4, 768};
    int vfp[2] = '{1, 3};
    int vsy[2] = '{1, 6};
    int vbp[2] = '{1, 29};

    int mh[2], mv[2];
    bit mnl[2], mnf[2];
    bit mpend;

    function automatic int ht(input int m);
        return ha[m] + hfp[m] + hsy[m] + hbp[m];
    endfunction

    function automatic int vt(input int m);
        return va[m] + vfp[m] + vsy[m] + vbp[m];
    endfunction

    // Model: position as a linear raster index that advances per tick or jumps to 0 on restart.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                mh[m] = ht(m) - 1;
                mv[m] = vt(m) - 1;
                mnl[m] = 0;
                mnf[m] = 0;
            end
            mpend = 0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (en) begin
                    int idx;
                    idx = (fr || mpend) ? 0 : (mv[m] * ht(m) + mh[m] + 1) % (ht(m) * vt(m));
                    mh[m] = idx % ht(m);
                    mv[m] = idx / ht(m);
                    mnl[m] = (mh[m] == 0);
                    mnf[m] = (idx == 0);
                end else begin
                    mnl[m] = 0;
                    mnf[m] = 0;
                end
            end
            mpend = !en && (mpend || fr);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string t, input int m, input bit ph, input bit pv, input int hc, input int vc,
                       input bit hs, input bit vs, input bit hb, input bit vb, input bit d, input bit nl, input bit nf);
        int h, v, hs0, vs0;
        h = mh[m];
        v = mv[m];
        hs0 = ha[m] + hfp[m];
        vs0 = va[m] + vfp[m];
        chk({t, ".hcount"}, hc, h);
        chk({t, ".vcount"}, vc, v);
        chk({t, ".hsync"}, hs, (h >= hs0 && h < hs0 + hsy[m]) ? ph : !ph);
        chk({t, ".vsync"}, vs, (v >= vs0 && v < vs0 + vsy[m]) ? pv : !pv);
        chk({t, ".hblnk"}, hb, h >= ha[m]);
        chk({t, ".vblnk"}, vb, v >= va[m]);
        chk({t, ".de"}, d, h < ha[m] && v < va[m]);
        chk({t, ".new_line"}, nl, mnl[m]);
        chk({t, ".new_frame"}, nf, mnf[m]);
    endtask

    bit cmp_on = 0;
    bit lit_on = 0;
    bit armed_f = 0;
    bit armed_l = 0;
    int div = 1;
    int ncyc = 0;
    int last_nf = 0;
    int last_nl = 0;
    int de_cnt = 0;
    int vs_cnt = 0;
    int hs_cnt = 0;

    // Per-cycle comparison against the model plus hand-derived frame/line literals.
    always @(negedge clk) begin
        if (cmp_on) begin
            cmp("a", 0, 1'b0, 1'b0, ia.hcount, ia.vcount, ia.hsync, ia.vsync, ia.hblnk, ia.vblnk, ia.de, ia.new_line, ia.new_frame);
            cmp("b", 0, 1'b1, 1'b1, ib.hcount, ib.vcount, ib.hsync, ib.vsync, ib.hblnk, ib.vblnk, ib.de, ib.new_line, ib.new_frame);
            cmp("c", 1, 1'b0, 1'b0, ic.hcount, ic.vcount, ic.hsync, ic.vsync, ic.hblnk, ic.vblnk, ic.de, ic.new_line, ic.new_frame);
            chk("a.hsync_low_10_11", ia.hsync, !(ia.hcount == 10 || ia.hcount == 11));
            chk("b.hsync_high_10_11", ib.hsync, ia.hcount == 10 || ia.hcount == 11);
            chk("a.hblnk_8_13", ia.hblnk, ia.hcount >= 8);
            chk("a.vsync_low_5", ia.vsync, ia.vcount != 5);
            if (lit_on) begin
                if (ia.new_frame) begin
                    if (armed_f) begin
                        chk("a.frame_period", ncyc - last_nf, 98 * div);
                        chk("a.de_per_frame", de_cnt, 32 * div);
                        chk("a.vsync_per_frame", vs_cnt, 14 * div);
                        chk("a.hsync_per_frame", hs_cnt, 14 * div);
                    end
                    armed_f = 1;
                    last_nf = ncyc;
                    de_cnt = 0;
                    vs_cnt = 0;
                    hs_cnt = 0;
                end
                de_cnt += int'(ia.de);
                vs_cnt += int'(!ia.vsync);
                hs_cnt += int'(!ia.hsync);
                if (ic.new_line) begin
                    if (armed_l) chk("c.line_period", ncyc - last_nl, 1344 * div);
                    armed_l = 1;
                    last_nl = ncyc;
                end
            end
            ncyc++;
        end
    end

    task automatic step(input bit e, input bit f);
        en = e;
        fr = f;
        @(posedge clk);
        #2;
    endtask

    task automatic new_phase(input int d);
        div = d;
        armed_f = 0;
        armed_l = 0;
        lit_on = 1;
    endtask

    task automatic chk_pos(input string nm, input int h, input int v, input int nf);
        chk({nm, ".h"}, ia.hcount, h);
        chk({nm, ".v"}, ia.vcount, v);
        chk({nm, ".nf"}, ia.new_frame, nf);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step(0, 0);
        chk("rst.a.hcount", ia.hcount, 13);
        chk("rst.a.vcount", ia.vcount, 6);
        chk("rst.a.de", ia.de, 0);
        chk("rst.a.hsync", ia.hsync, 1);
        chk("rst.b.hsync", ib.hsync, 0);
        chk("rst.b.vsync", ib.vsync, 0);
        chk("rst.c.hcount", ic.hcount, 1343);
        chk("rst.c.vcount", ic.vcount, 805);
        cmp_on = 1;
        rst_n = 1;
        step(1, 0);
        chk_pos("first_tick", 0, 0, 1);
        chk("first_tick.nl", ia.new_line, 1);
        chk("first_tick.c.h", ic.hcount, 0);
        chk("first_tick.c.nf", ic.new_frame, 1);
        step(1, 0);
        chk_pos("second_tick", 1, 0, 0);
        new_phase(1);
        repeat (300) step(1, 0);
        new_phase(3);
        for (int k = 0; k < 900; k++) step(k % 3 == 2, 0);
        new_phase(1);
        repeat (3000) step(1, 0);
        lit_on = 0;
        for (int i = 0; i < 200 && !(ia.hcount == 5 && ia.vcount == 2); i++) step(1, 0);
        chk_pos("at_5_2", 5, 2, 0);
        step(1, 1);
        chk_pos("restart_5_2", 0, 0, 1);
        step(1, 0);
        chk_pos("after_restart", 1, 0, 0);
        step(0, 0);
        step(0, 1);
        step(0, 0);
        step(0, 1);
        step(0, 0);
        chk_pos("pending_hold", 1, 0, 0);
        step(1, 0);
        chk_pos("pending_restart", 0, 0, 1);
        step(1, 0);
        chk_pos("pending_single", 1, 0, 0);
        for (int i = 0; i < 200 && !(ia.hcount == 13 && ia.vcount == 6); i++) step(1, 0);
        chk_pos("at_wrap", 13, 6, 0);
        step(1, 1);
        chk_pos("restart_at_wrap", 0, 0, 1);
        step(1, 1);
        chk_pos("restart_at_origin", 0, 0, 1);
        step(1, 0);
        chk_pos("after_origin", 1, 0, 0);
        for (int i = 0; i < 2000 && ic.hcount != 600; i++) step(1, 0);
        chk("c.at_600", ic.hcount, 600);
        step(0, 1);
        rst_n = 0;
        #1;
        chk("midrst.c.hcount", ic.hcount, 1343);
        chk("midrst.c.vcount", ic.vcount, 805);
        chk("midrst.c.hblnk", ic.hblnk, 1);
        chk("midrst.c.vblnk", ic.vblnk, 1);
        chk("midrst.c.de", ic.de, 0);
        chk("midrst.c.hsync", ic.hsync, 1);
        chk("midrst.c.vsync", ic.vsync, 1);
        chk("midrst.c.new_line", ic.new_line, 0);
        step(0, 0);
        step(0, 0);
        rst_n = 1;
        step(1, 0);
        chk_pos("post_rst", 0, 0, 1);
        step(1, 0);
        chk_pos("post_rst2", 1, 0, 0);
        cmp_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
